// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register for a single-issue ARM-style core.
// It captures the decoded instruction fields on every clock edge. The freeze input
// holds the current contents, and the flush input loads an all-zero bubble.
// Flush has priority over freeze.
// Optional build macro ID_EXE_BUBBLE_CNT_EN adds a 16-bit saturating bubble_cnt output.
// That counter counts each clock edge on which the stage stalls or is flushed.
module id_exe_reg #(
    parameter int unsigned REGISTER_LEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic [REGISTER_LEN-1:0] pc_in,
    input  logic [REGISTER_LEN-1:0] val_rn_in,
    input  logic [REGISTER_LEN-1:0] val_rm_in,
    input  logic [11:0]             shift_operand_in,
    input  logic                    imm_in,
    input  logic [23:0]             signed_imm_24_in,
    input  logic [3:0]              exe_cmd_in,
    input  logic [3:0]              dest_in,
    input  logic [3:0]              status_in,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    s_in,
    input  logic                    b_in,
    output logic                    valid_out,
    output logic [REGISTER_LEN-1:0] pc_out,
    output logic [REGISTER_LEN-1:0] val_rn_out,
    output logic [REGISTER_LEN-1:0] val_rm_out,
    output logic [11:0]             shift_operand_out,
    output logic                    imm_out,
    output logic [23:0]             signed_imm_24_out,
    output logic [3:0]              exe_cmd_out,
    output logic [3:0]              dest_out,
    output logic [3:0]              status_out,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    s_out,
    output logic                    b_out,
    output logic                    is_mem_command_out
`ifdef ID_EXE_BUBBLE_CNT_EN
    ,
    output logic [15:0]             bubble_cnt
`endif
);

    // Every stored field of the stage, kept together so that a bubble is simply '0.
    typedef struct packed {
        logic                    valid;
        logic [REGISTER_LEN-1:0] pc;
        logic [REGISTER_LEN-1:0] val_rn;
        logic [REGISTER_LEN-1:0] val_rm;
        logic [11:0]             shift_operand;
        logic                    imm;
        logic [23:0]             signed_imm_24;
        logic [3:0]              exe_cmd;
        logic [3:0]              dest;
        logic [3:0]              status;
        logic                    wb_en;
        logic                    mem_r_en;
        logic                    mem_w_en;
        logic                    s;
        logic                    b;
    } stage_t;

    stage_t stage_d, stage_q;

    // Next-state selection: flush beats freeze, and freeze beats a normal load.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!freeze) begin
            stage_d.valid         = valid_in;
            stage_d.pc            = pc_in;
            stage_d.val_rn        = val_rn_in;
            stage_d.val_rm        = val_rm_in;
            stage_d.shift_operand = shift_operand_in;
            stage_d.imm           = imm_in;
            stage_d.signed_imm_24 = signed_imm_24_in;
            stage_d.exe_cmd       = exe_cmd_in;
            stage_d.dest          = dest_in;
            stage_d.status        = status_in;
            // Gate control bits with valid so that an empty slot never commits side effects.
            stage_d.wb_en         = wb_en_in & valid_in;
            stage_d.mem_r_en      = mem_r_en_in & valid_in;
            stage_d.mem_w_en      = mem_w_en_in & valid_in;
            stage_d.s             = s_in & valid_in;
            stage_d.b             = b_in & valid_in;
        end
    end

    // Stage register with asynchronous clear. The clear also drops a frozen instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_out         = stage_q.valid;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign shift_operand_out = stage_q.shift_operand;
    assign imm_out           = stage_q.imm;
    assign signed_imm_24_out = stage_q.signed_imm_24;
    assign exe_cmd_out       = stage_q.exe_cmd;
    assign dest_out          = stage_q.dest;
    assign status_out        = stage_q.status;
    assign wb_en_out         = stage_q.wb_en;
    assign mem_r_en_out      = stage_q.mem_r_en;
    assign mem_w_en_out      = stage_q.mem_w_en;
    assign s_out             = stage_q.s;
    assign b_out             = stage_q.b;

    // Derived only from stored enables, so the output is glitch-free relative to the inputs.
    assign is_mem_command_out = stage_q.mem_r_en | stage_q.mem_w_en;

`ifdef ID_EXE_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    // Count each stalled or flushed edge once, and saturate at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((flush || freeze) && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: randomized and directed bench for id_exe_reg.
// A reference model pushes the expected stage contents for every clock edge.
// A monitor process pops each expected value and compares it after the edge.
module tb_id_exe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] shop;
        logic        imm;
        logic [23:0] simm;
        logic [3:0]  cmd;
        logic [3:0]  dest;
        logic [3:0]  status;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        s;
        logic        b;
        logic        ismem;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    pkt_t        din = '0;
    logic        valid_out, imm_out, wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out;
    logic        is_mem_command_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  exe_cmd_out, dest_out, status_out;
`ifdef ID_EXE_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] cnt_mdl = '0;
    logic [15:0] cnt_q[$];
`endif

    int   n_total = 0;
    int   n_pass  = 0;
    pkt_t mdl     = '0;
    pkt_t exp_q[$];

    always #5 clk = ~clk;

    id_exe_reg #(.REGISTER_LEN(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .freeze             (freeze),
        .flush              (flush),
        .valid_in           (din.valid),
        .pc_in              (din.pc),
        .val_rn_in          (din.rn),
        .val_rm_in          (din.rm),
        .shift_operand_in   (din.shop),
        .imm_in             (din.imm),
        .signed_imm_24_in   (din.simm),
        .exe_cmd_in         (din.cmd),
        .dest_in            (din.dest),
        .status_in          (din.status),
        .wb_en_in           (din.wb),
        .mem_r_en_in        (din.mr),
        .mem_w_en_in        (din.mw),
        .s_in               (din.s),
        .b_in               (din.b),
        .valid_out          (valid_out),
        .pc_out             (pc_out),
        .val_rn_out         (val_rn_out),
        .val_rm_out         (val_rm_out),
        .shift_operand_out  (shift_operand_out),
        .imm_out            (imm_out),
        .signed_imm_24_out  (signed_imm_24_out),
        .exe_cmd_out        (exe_cmd_out),
        .dest_out           (dest_out),
        .status_out         (status_out),
        .wb_en_out          (wb_en_out),
        .mem_r_en_out       (mem_r_en_out),
        .mem_w_en_out       (mem_w_en_out),
        .s_out              (s_out),
        .b_out              (b_out),
        .is_mem_command_out (is_mem_command_out)
`ifdef ID_EXE_BUBBLE_CNT_EN
        ,
        .bubble_cnt         (bubble_cnt)
`endif
    );

    function automatic pkt_t sample();
        pkt_t p;
        p.valid  = valid_out;
        p.pc     = pc_out;
        p.rn     = val_rn_out;
        p.rm     = val_rm_out;
        p.shop   = shift_operand_out;
        p.imm    = imm_out;
        p.simm   = signed_imm_24_out;
        p.cmd    = exe_cmd_out;
        p.dest   = dest_out;
        p.status = status_out;
        p.wb     = wb_en_out;
        p.mr     = mem_r_en_out;
        p.mw     = mem_w_en_out;
        p.s      = s_out;
        p.b      = b_out;
        p.ismem  = is_mem_command_out;
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.valid  = ($urandom_range(3) != 0);
        p.pc     = $urandom;
        p.rn     = $urandom;
        p.rm     = $urandom;
        p.shop   = 12'($urandom);
        p.imm    = 1'($urandom);
        p.simm   = 24'($urandom);
        p.cmd    = 4'($urandom);
        p.dest   = 4'($urandom);
        p.status = 4'($urandom);
        p.wb     = 1'($urandom);
        p.mr     = 1'($urandom);
        p.mw     = 1'($urandom);
        p.s      = 1'($urandom);
        p.b      = 1'($urandom);
        p.ismem  = 1'b0;
        return p;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one cycle of stimulus and record what the stage must hold after the edge.
    // An empty slot carries no side effects. Data bits pass through unchanged.
    task automatic step(input pkt_t in, input logic frz, input logic fls);
        din    = in;
        freeze = frz;
        flush  = fls;
        @(posedge clk);
        if (fls) begin
            mdl = '0;
        end else if (!frz) begin
            mdl = in;
            if (!in.valid) {mdl.wb, mdl.mr, mdl.mw, mdl.s, mdl.b} = 5'b0;
        end
        mdl.ismem = mdl.mr | mdl.mw;
        exp_q.push_back(mdl);
`ifdef ID_EXE_BUBBLE_CNT_EN
        if ((fls || frz) && cnt_mdl != 16'hFFFF) cnt_mdl = cnt_mdl + 16'd1;
        cnt_q.push_back(cnt_mdl);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_outputs", 160'(sample()), 160'd0);
        @(negedge clk);
        @(negedge clk);
        mdl = '0;
`ifdef ID_EXE_BUBBLE_CNT_EN
        cnt_mdl = '0;
        chk("reset_bubble_cnt", 160'(bubble_cnt), 160'd0);
`endif
        rst = 1'b0;
    endtask

    // Monitor: compare the DUT against each expected value shortly after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                pkt_t e;
                e = exp_q.pop_front();
                chk("scoreboard", 160'(sample()), 160'(e));
`ifdef ID_EXE_BUBBLE_CNT_EN
                chk("sb_bubble_cnt", 160'(bubble_cnt), 160'(cnt_q.pop_front()));
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        @(negedge clk);
        do_reset();

        // Passthrough with a one-cycle latency.
        p = '0; p.valid = 1'b1; p.rm = 32'hDEADBEEF; p.shop = 12'h4FF; p.imm = 1'b1;
        din = p;
        #1;
        chk("pass_before_edge", 160'({valid_out, val_rm_out}), 160'(33'h0));
        @(negedge clk);
        step(p, 1'b0, 1'b0);
        chk("pass_rm", 160'(val_rm_out), 160'(32'hDEADBEEF));
        chk("pass_shop", 160'(shift_operand_out), 160'(12'h4FF));
        chk("pass_imm_valid", 160'({imm_out, valid_out}), 160'(2'b11));

        // is_mem_command follows the stored memory enables.
        p = '0; p.valid = 1'b1; p.mr = 1'b1;
        step(p, 1'b0, 1'b0);
        chk("ismem_set", 160'(is_mem_command_out), 160'(1'b1));
        p.mr = 1'b0;
        step(p, 1'b0, 1'b0);
        chk("ismem_clr", 160'(is_mem_command_out), 160'(1'b0));

        // Freeze holds the current instruction for three cycles.
        p = '0; p.valid = 1'b1; p.cmd = 4'b0100;
        step(p, 1'b0, 1'b0);
        p.cmd = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step(p, 1'b1, 1'b0);
            chk("freeze_hold", 160'(exe_cmd_out), 160'(4'b0100));
        end
        step(p, 1'b0, 1'b0);
        chk("freeze_release", 160'(exe_cmd_out), 160'(4'b0010));

        // Flush takes priority over freeze.
        p = '0; p.valid = 1'b1; p.wb = 1'b1; p.mw = 1'b1;
        step(p, 1'b0, 1'b0);
        chk("flush_pre", 160'({wb_en_out, mem_w_en_out, is_mem_command_out}), 160'(3'b111));
        step(p, 1'b1, 1'b1);
        chk("flush_over_freeze",
            160'({valid_out, wb_en_out, mem_w_en_out, is_mem_command_out}), 160'(4'b0));

        // Asynchronous reset while stalled, between clock edges.
        p = '0; p.valid = 1'b1; p.pc = 32'h0000_0040;
        step(p, 1'b0, 1'b0);
        chk("async_pre_pc", 160'(pc_out), 160'(32'h40));
        freeze = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 160'({pc_out, valid_out}), 160'(33'h0));
        @(negedge clk);
        mdl = '0;
`ifdef ID_EXE_BUBBLE_CNT_EN
        cnt_mdl = '0;
`endif
        rst = 1'b0;
        step(p, 1'b1, 1'b0);
        chk("stall_after_rst", 160'({pc_out, valid_out}), 160'(33'h0));

        // Randomized traffic with random freeze and flush.
        for (int i = 0; i < 400; i++) begin
            step(rand_pkt(), ($urandom_range(3) == 0), ($urandom_range(7) == 0));
        end

`ifdef ID_EXE_BUBBLE_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) step(rand_pkt(), 1'b1, (i == 2));
        step(rand_pkt(), 1'b0, 1'b1);
        chk("bubble_six", 160'(bubble_cnt), 160'(16'd6));
        for (int i = 0; i < 65535 - 6; i++) step('0, 1'b1, 1'b0);
        chk("bubble_full", 160'(bubble_cnt), 160'(16'hFFFF));
        step('0, 1'b0, 1'b1);
        chk("bubble_saturate", 160'(bubble_cnt), 160'(16'hFFFF));
`endif

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 160'(exp_q.size()), 160'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have freeze  input  1  hazard stall; hold all stored fields.
REQ-004 SHALL have flush  input  1  taken-branch kill; load a bubble.
REQ-005 SHALL have valid_in / valid_out  1  instruction-present flag.
REQ-006 SHALL have pc_in / pc_out  REGISTER_LEN  instruction PC+4.
REQ-007 SHALL have val_rn_in / val_rn_out and val_rm_in / val_rm_out  REGISTER_LEN each  register-file read data.
REQ-008 SHALL have shift_operand_in / shift_operand_out  12  raw shifter operand field.
REQ-009 SHALL have imm_in / imm_out  1  I bit.
REQ-010 SHALL have signed_imm_24_in / signed_imm_24_out  24  branch offset.
REQ-011 SHALL have exe_cmd_in / exe_cmd_out  4  ALU opcode.
REQ-012 SHALL have dest_in / dest_out  4  destination register number.
REQ-013 SHALL have status_in / status_out  4  NZCV snapshot at decode.
REQ-014 SHALL have control pairs wb_en, mem_r_en, mem_w_en, s, b (_in / _out)  1 each.
REQ-015 SHALL have is_mem_command_out  output  1  registered mem_r_en OR mem_w_en.

Function
REQ-016 SHALL, on each rising clk with flush=0 and freeze=0, load every *_in into the matching *_out.
REQ-017 SHALL give a latency of exactly one cycle from *_in to *_out.
REQ-018 SHALL, with freeze=1 and flush=0, hold every output unchanged for as many cycles as freeze stays high.
REQ-019 SHALL, with flush=1, load a bubble: valid, wb_en, mem_r_en, mem_w_en, s, b, exe_cmd cleared to 0; data fields (pc, val_rn, val_rm, shift_operand, imm, signed_imm_24, dest, status) also cleared to 0.
REQ-020 SHALL give flush priority over freeze when both are high in the same cycle.
REQ-021 SHALL derive is_mem_command_out only from the stored mem_r_en_out/mem_w_en_out, never from inputs.
REQ-022 SHALL, whenever valid_out=0, keep wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out at 0.
REQ-023 SHALL pass values unmodified (no sign extension, shifting or decoding of shift_operand or signed_imm_24).

Reset
REQ-024 SHALL, while rst=1, force all outputs to 0 immediately, independent of clk.
REQ-025 SHALL, on rst release, capture on the first rising clk following the rules of REQ-016..020.
REQ-026 SHALL discard any held (frozen) instruction when rst asserts mid-stall.

Configuration
REQ-027 SHALL, with macro ID_EXE_BUBBLE_CNT_EN defined, add output bubble_cnt (16 bits, reset 0) that increments by 1 on each rising clk where flush=1 or freeze=1 (flush and freeze together count once), saturating at 16'hFFFF.
REQ-028 SHALL, without ID_EXE_BUBBLE_CNT_EN, omit the bubble_cnt port and counter entirely; all other behaviour identical.

Verification
REQ-029 SHALL verify passthrough: val_rm_in=32'hDEADBEEF, shift_operand_in=12'h4FF, imm_in=1, valid_in=1 -> exactly one clk later val_rm_out=32'hDEADBEEF, shift_operand_out=12'h4FF, imm_out=1, valid_out=1.
REQ-030 SHALL verify freeze: load exe_cmd=4'b0100, then freeze=1 for 3 cycles with exe_cmd_in=4'b0010 -> exe_cmd_out stays 4'b0100 for 3 cycles, becomes 4'b0010 on the first clk after freeze drops.
REQ-031 SHALL verify flush-over-freeze: stored wb_en=1, mem_w_en=1; assert flush=1 and freeze=1 together -> next clk valid_out=0, wb_en_out=0, mem_w_en_out=0, is_mem_command_out=0.
REQ-032 SHALL verify async reset: outputs loaded with pc_out=32'h00000040; assert rst between clock edges -> pc_out=0 and valid_out=0 before the next rising clk.
REQ-033 SHALL verify is_mem_command: mem_r_en_in=1, mem_w_en_in=0 -> next clk is_mem_command_out=1; then both 0 -> next clk 0.
REQ-034 SHALL verify ID_EXE_BUBBLE_CNT_EN build: 5 freeze cycles plus 2 flush cycles (one overlapping freeze) -> bubble_cnt=6; preload 16'hFFFF and stall once more -> stays 16'hFFFF.
